// File: rtl/param_reg_ram.sv
// param_reg_ram: parametrised single-port RAM with hardware clear sweep, busy flag and optional registered read
module param_reg_ram #(
   parameter int WIDTH   = 16,
   parameter int ADDR_W  = 3,
   parameter bit REG_OUT = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   output logic [WIDTH-1:0]  out,
   output logic              busy
);
   localparam int DEPTH = 2**ADDR_W;
   typedef enum logic {CLEAR, READY} state_t;
   state_t state, state_d;
   logic [ADDR_W-1:0] clr_addr;
   logic [WIDTH-1:0] mem [DEPTH];
   always_comb begin
      state_d = state;
      if (state == CLEAR && clr_addr == '1) state_d = READY;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= CLEAR;
         clr_addr <= '0;
      end else begin
         state <= state_d;
         if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR) mem[clr_addr] <= '0;
         else if (load) mem[address] <= in;
      end
   end
   assign busy = !rst_n || state == CLEAR;
   generate
      if (REG_OUT) begin : g_reg
         logic [WIDTH-1:0] out_q;
         // read-first: samples the word before any same-edge write lands
         always_ff @(posedge clk) out_q <= busy ? '0 : mem[address];
         assign out = busy ? '0 : out_q;
      end else begin : g_comb
         assign out = busy ? '0 : mem[address];
      end
   endgenerate
endmodule

// File: tb/tb_param_reg_ram.sv
// tb_param_reg_ram: scoreboard bench for comb/registered 8x16 RAMs and a 64x8 RAM
module tb_param_reg_ram;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_a, load_a, rst_b, load_b;
   logic [15:0] din_a, out0, out1;
   logic [2:0] addr_a;
   logic [7:0] din_b, outb;
   logic [5:0] addr_b;
   logic busy0, busy1, busyb;
   param_reg_ram #(.WIDTH(16), .ADDR_W(3), .REG_OUT(1'b0)) d0 (.clk(clk), .rst_n(rst_a), .in(din_a), .load(load_a), .address(addr_a), .out(out0), .busy(busy0));
   param_reg_ram #(.WIDTH(16), .ADDR_W(3), .REG_OUT(1'b1)) d1 (.clk(clk), .rst_n(rst_a), .in(din_a), .load(load_a), .address(addr_a), .out(out1), .busy(busy1));
   param_reg_ram #(.WIDTH(8), .ADDR_W(6), .REG_OUT(1'b0)) d2 (.clk(clk), .rst_n(rst_b), .in(din_b), .load(load_b), .address(addr_b), .out(outb), .busy(busyb));
   typedef struct {
      logic        busy_a;
      logic [15:0] o0;
      logic [15:0] o1;
      logic        busy_b;
      logic [7:0]  ob;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int checks = 0;
   int errors = 0;
   logic [15:0] ma [8];
   logic [7:0] mb [64];
   logic [15:0] r1 = '0;
   int cnt_a = 8;
   int cnt_b = 64;
   task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", n, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("busy0", {15'd0, busy0}, {15'd0, e.busy_a});
         chk("busy1", {15'd0, busy1}, {15'd0, e.busy_a});
         chk("out0", out0, e.o0);
         chk("out1", out1, e.o1);
         chk("busyb", {15'd0, busyb}, {15'd0, e.busy_b});
         chk("outb", {8'd0, outb}, {8'd0, e.ob});
      end
   end
   // Model: a reset arms a DEPTH-cycle busy window; contents vanish when it ends.
   task automatic step();
      exp_t x;
      x.busy_a = !rst_a || cnt_a > 0;
      x.o0 = x.busy_a ? 16'h0 : ma[addr_a];
      x.o1 = x.busy_a ? 16'h0 : r1;
      x.busy_b = !rst_b || cnt_b > 0;
      x.ob = x.busy_b ? 8'h0 : mb[addr_b];
      q.push_back(x);
      @(posedge clk);
      if (!rst_a) begin
         cnt_a = 8;
         r1 = '0;
      end else if (cnt_a > 0) begin
         cnt_a--;
         r1 = '0;
         if (cnt_a == 0) foreach (ma[i]) ma[i] = '0;
      end else begin
         r1 = ma[addr_a];
         if (load_a) ma[addr_a] = din_a;
      end
      if (!rst_b) cnt_b = 64;
      else if (cnt_b > 0) begin
         cnt_b--;
         if (cnt_b == 0) foreach (mb[i]) mb[i] = '0;
      end else if (load_b) mb[addr_b] = din_b;
      #1;
   endtask
   task automatic wr_a(input int a, input logic [15:0] d);
      addr_a = 3'(a); din_a = d; load_a = 1'b1; step(); load_a = 1'b0;
   endtask
   task automatic rd_all_a();
      for (int i = 0; i < 9; i++) begin
         addr_a = 3'(i % 8); din_a = 16'($urandom); step();
      end
   endtask
   task automatic rd_all_b();
      for (int i = 0; i < 65; i++) begin
         addr_b = 6'(i % 64); din_b = 8'($urandom); step();
      end
   endtask
   initial begin
      foreach (ma[i]) ma[i] = 'x;
      foreach (mb[i]) mb[i] = 'x;
      rst_a = 1'b0; load_a = 1'b0; din_a = '0; addr_a = '0;
      rst_b = 1'b0; load_b = 1'b0; din_b = '0; addr_b = '0;
      @(posedge clk); #1;
      step(); step();
      rst_a = 1'b1; rst_b = 1'b1; load_a = 1'b1; din_a = 16'hFFFF;
      for (int i = 0; i < 8; i++) begin
         addr_a = 3'(i); step();
      end
      load_a = 1'b0;
      rd_all_a();
      wr_a(0, 16'h1234); wr_a(5, 16'h1424); wr_a(7, 16'hAAAA); wr_a(4, 16'hB123);
      rd_all_a();
      wr_a(2, 16'h10C4); wr_a(2, 16'h1CC4);
      addr_a = 3'd5; din_a = 16'h1114; step();
      rd_all_a();
      wr_a(5, 16'hFFFF);
      step(); step(); step();
      rst_a = 1'b0; step(); rst_a = 1'b1;
      step(); step(); step();
      rst_a = 1'b0; step(); rst_a = 1'b1;
      for (int i = 0; i < 10; i++) begin
         load_a = 1'b1; din_a = 16'hFFFF; addr_a = 3'(i); step();
      end
      load_a = 1'b0;
      rd_all_a();
      for (int i = 0; i < 64; i++) begin
         addr_b = 6'(i); din_b = 8'(1 << (i % 8)) ^ 8'(i >> 3); load_b = 1'b1;
         addr_a = 3'($urandom_range(0, 7)); step();
      end
      load_b = 1'b0;
      rd_all_b();
      rst_b = 1'b0; step(); rst_b = 1'b1;
      load_b = 1'b1; din_b = 8'hFF;
      for (int i = 0; i < 66; i++) begin
         addr_b = 6'($urandom_range(0, 63)); step();
      end
      load_b = 1'b0;
      rd_all_b();
      for (int i = 0; i < 300; i++) begin
         rst_a = $urandom_range(0, 59) != 0;
         rst_b = $urandom_range(0, 99) != 0;
         load_a = 1'($urandom); din_a = 16'($urandom); addr_a = 3'($urandom_range(0, 7));
         load_b = 1'($urandom); din_b = 8'($urandom); addr_b = 6'($urandom_range(0, 63));
         step();
      end
      rst_a = 1'b1; rst_b = 1'b1; load_a = 1'b0; load_b = 1'b0;
      repeat (4) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain left %0d exp 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
